bcd_accum_bank: RTL and testbench

- Bank of CHANNELS independent multi-digit BCD accumulators with add, subtract and clear commands.
- Each command is edge-triggered from a level input and applies to the channel on select.
- Add/subtract runs digit-serially, least significant digit first, one digit per clock, with ripple carry/borrow.
- data_out presents the selected channel's value. The block serves as the counting/arithmetic core for the front-panel display datapath.

---
 rtl/bcd_accum_bank_if.sv | 27 ++
 rtl/bcd_accum_bank.sv | 193 +++++++++++++++++++
 tb/tb_bcd_accum_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_accum_bank_if.sv
// Command/status bundle between a controller and the BCD accumulator bank.
// The controller drives select, the command levels and the operand. The bank
// drives back the displayed value and its status.
interface bcd_accum_bank_if #(
  parameter int DIGITS = 2,
  parameter int SEL_W  = 2
);
  logic [SEL_W-1:0]    select;
  logic                add;
  logic                sub;
  logic                clear;
  logic [4*DIGITS-1:0] data_in;
  logic [4*DIGITS-1:0] data_out;
  logic                wrap_out;
  logic                busy;
  logic                done;

  modport master (
    output select, add, sub, clear, data_in,
    input  data_out, wrap_out, busy, done
  );

  modport slave (
    input  select, add, sub, clear, data_in,
    output data_out, wrap_out, busy, done
  );
endinterface

// File: rtl/bcd_accum_bank.sv
// Bank of independent multi-digit BCD accumulators.
// Add and subtract run one digit per clock, least significant digit first.
// Clear acts at once. Commands fire on the rising edge of a level input.
// The value and wrap flag of the selected channel come out of registers, so a
// digit write or a clear shows on the outputs at the same edge it happens.
module bcd_accum_bank #(
  parameter int CHANNELS = 4,
  parameter int DIGITS   = 2,
  parameter int SEL_W    = 2
) (
  input logic              clk,
  input logic              rst_n,
  bcd_accum_bank_if.slave  bus
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef logic [DIGITS-1:0][3:0] bcd_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Clamp an out-of-range operand digit to 9 so the stored digits stay valid BCD.
  function automatic logic [3:0] sat_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  state_t           state_q, state_d;
  bcd_t             acc_q [CHANNELS];
  bcd_t             acc_d [CHANNELS];
  logic             wrap_q [CHANNELS];
  logic             wrap_d [CHANNELS];
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             sub_mode_q, sub_mode_d;
  bcd_t             op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             add_q, sub_q, clear_q;
  bcd_t             data_out_q, data_out_d;
  logic             wrap_out_q, wrap_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             add_rise_s, sub_rise_s, clear_rise_s;
  logic [CH_W-1:0]  sel_ch_s;
  bcd_t             data_in_s;
  logic [3:0]       cur_dig_s, op_dig_s, new_dig_s;
  logic [4:0]       sum_s, need_s;
  logic             carry_new_s;

  assign add_rise_s   = bus.add   & ~add_q;
  assign sub_rise_s   = bus.sub   & ~sub_q;
  assign clear_rise_s = bus.clear & ~clear_q;
  assign data_in_s    = bus.data_in;

  assign bus.data_out = data_out_q;
  assign bus.wrap_out = wrap_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Map out-of-range selects onto channel 0.
  always_comb begin
    if ({1'b0, bus.select} >= CH_LIM) begin
      sel_ch_s = '0;
    end else begin
      sel_ch_s = CH_W'(bus.select);
    end
  end

  // Arithmetic on one digit: the ripple add/subtract of the current digit.
  always_comb begin
    cur_dig_s   = acc_q[ch_q][idx_q];
    op_dig_s    = op_q[idx_q];
    sum_s       = {1'b0, cur_dig_s} + {1'b0, op_dig_s} + {4'b0000, carry_q};
    need_s      = {1'b0, op_dig_s} + {4'b0000, carry_q};
    new_dig_s   = 4'd0;
    carry_new_s = 1'b0;
    if (sub_mode_q) begin
      if ({1'b0, cur_dig_s} < need_s) begin
        new_dig_s   = 4'(({1'b0, cur_dig_s} + 5'd10) - need_s);
        carry_new_s = 1'b1;
      end else begin
        new_dig_s   = 4'({1'b0, cur_dig_s} - need_s);
        carry_new_s = 1'b0;
      end
    end else begin
      if (sum_s > 5'd9) begin
        new_dig_s   = 4'(sum_s - 5'd10);
        carry_new_s = 1'b1;
      end else begin
        new_dig_s   = sum_s[3:0];
        carry_new_s = 1'b0;
      end
    end
  end

  // Next state: command decode in IDLE, one digit write per cycle in RUN, output view.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    wrap_d     = wrap_q;
    ch_d       = ch_q;
    sub_mode_d = sub_mode_q;
    op_d       = op_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_rise_s) begin
          acc_d[sel_ch_s]  = '0;
          wrap_d[sel_ch_s] = 1'b0;
        end else if (add_rise_s ^ sub_rise_s) begin
          ch_d       = sel_ch_s;
          sub_mode_d = sub_rise_s;
          for (int i = 0; i < DIGITS; i++) begin
            op_d[i] = sat_bcd(data_in_s[i]);
          end
          idx_d   = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[ch_q][idx_q] = new_dig_s;
        carry_d = carry_new_s;
        if (idx_q == IDX_LAST) begin
          if (carry_new_s) begin
            wrap_d[ch_q] = 1'b1;
          end else begin
            wrap_d[ch_q] = wrap_q[ch_q];
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    data_out_d = acc_d[sel_ch_s];
    wrap_out_d = wrap_d[sel_ch_s];
  end

  // State, accumulator storage, edge history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]  <= '0;
        wrap_q[c] <= 1'b0;
      end
      ch_q       <= '0;
      sub_mode_q <= 1'b0;
      op_q       <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      add_q      <= 1'b0;
      sub_q      <= 1'b0;
      clear_q    <= 1'b0;
      data_out_q <= '0;
      wrap_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wrap_q     <= wrap_d;
      ch_q       <= ch_d;
      sub_mode_q <= sub_mode_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      add_q      <= bus.add;
      sub_q      <= bus.sub;
      clear_q    <= bus.clear;
      data_out_q <= data_out_d;
      wrap_out_q <= wrap_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_accum_bank.sv
// Directed bench for bcd_accum_bank with CHANNELS=4 and DIGITS=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bcd_accum_bank;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  bcd_accum_bank_if #(.DIGITS(2), .SEL_W(2)) bus();

  bcd_accum_bank #(.CHANNELS(4), .DIGITS(2), .SEL_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop a run that hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Wait for done, with a bound on the number of cycles.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk1(tag, bus.done, 1'b1);
  endtask

  // Issue one add or subtract on a channel and let it finish.
  task automatic do_op(input string tag, input logic is_sub, input logic [1:0] sel,
                       input logic [7:0] data);
    bus.select  = sel;
    bus.data_in = data;
    if (is_sub) bus.sub = 1'b1;
    else        bus.add = 1'b1;
    tick();
    bus.add = 1'b0;
    bus.sub = 1'b0;
    wait_done(tag);
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.select  = 2'd0;
    bus.add     = 1'b0;
    bus.sub     = 1'b0;
    bus.clear   = 1'b0;
    bus.data_in = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk8("rst_data", bus.data_out, 8'h00);
    chk1("rst_wrap", bus.wrap_out, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);

    // First add, traced one cycle at a time: ch1 += 47
    bus.select  = 2'd1;
    bus.data_in = 8'h47;
    bus.add     = 1'b1;
    tick();
    bus.add = 1'b0;
    chk1("add1_busy_e1", bus.busy, 1'b1);
    chk1("add1_done_e1", bus.done, 1'b0);
    tick();
    chk1("add1_busy_e2", bus.busy, 1'b1);
    chk8("add1_partial", bus.data_out, 8'h07);
    tick();
    chk1("add1_busy_e3", bus.busy, 1'b0);
    chk1("add1_done_e3", bus.done, 1'b1);
    chk8("add1_value", bus.data_out, 8'h47);
    tick();
    chk1("add1_done_low", bus.done, 1'b0);

    // 47 + 58 = 105 -> 05 with wrap
    do_op("add2_done", 1'b0, 2'd1, 8'h58);
    chk8("add2_value", bus.data_out, 8'h05);
    chk1("add2_wrap", bus.wrap_out, 1'b1);

    // Other channels untouched
    bus.select = 2'd0; tick(); chk8("ch0_zero", bus.data_out, 8'h00);
    bus.select = 2'd2; tick(); chk8("ch2_zero", bus.data_out, 8'h00);
    bus.select = 2'd3; tick(); chk8("ch3_zero", bus.data_out, 8'h00);

    // 00 - 01 -> 99 with wrap (ten's complement)
    do_op("sub1_done", 1'b1, 2'd2, 8'h01);
    chk8("sub1_value", bus.data_out, 8'h99);
    chk1("sub1_wrap", bus.wrap_out, 1'b1);

    // Clear shows at the same edge
    bus.clear = 1'b1;
    tick();
    chk8("clr_value", bus.data_out, 8'h00);
    chk1("clr_wrap", bus.wrap_out, 1'b0);
    chk1("clr_busy", bus.busy, 1'b0);
    bus.clear = 1'b0;
    tick();

    // Carry across digits without wrap: 19 + 01 = 20, then 20 - 05 = 15
    do_op("add3_done", 1'b0, 2'd2, 8'h19);
    do_op("add4_done", 1'b0, 2'd2, 8'h01);
    chk8("carry_value", bus.data_out, 8'h20);
    chk1("carry_wrap", bus.wrap_out, 1'b0);
    do_op("sub2_done", 1'b1, 2'd2, 8'h05);
    chk8("borrow_value", bus.data_out, 8'h15);
    chk1("borrow_wrap", bus.wrap_out, 1'b0);

    // A held level gives exactly one add
    bus.select  = 2'd3;
    bus.data_in = 8'h03;
    bus.add     = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.add = 1'b0;
    tick();
    chk8("held_value", bus.data_out, 8'h03);
    chk1("held_busy", bus.busy, 1'b0);

    // Add and sub rising in the same cycle do nothing
    bus.data_in = 8'h05;
    bus.add = 1'b1;
    bus.sub = 1'b1;
    tick();
    chk1("both_busy", bus.busy, 1'b0);
    tick();
    chk8("both_value", bus.data_out, 8'h03);
    bus.add = 1'b0;
    bus.sub = 1'b0;
    tick();

    // Busy: the select change and the second add during RUN are ignored by the operation
    bus.select  = 2'd0;
    bus.data_in = 8'h12;
    bus.add     = 1'b1;
    tick();
    bus.add    = 1'b0;
    bus.select = 2'd3;
    bus.data_in = 8'h44;
    chk1("run_busy", bus.busy, 1'b1);
    tick();
    chk8("run_sel_view", bus.data_out, 8'h03);
    bus.add = 1'b1;
    tick();
    chk1("run_done", bus.done, 1'b1);
    chk8("run_ch3_keep", bus.data_out, 8'h03);
    bus.add = 1'b0;
    tick();
    chk1("run_drop_busy", bus.busy, 1'b0);
    bus.select = 2'd0;
    tick();
    chk8("run_ch0_value", bus.data_out, 8'h12);

    // Reset between the two digit edges aborts the operation
    bus.select  = 2'd1;
    bus.data_in = 8'h11;
    bus.add     = 1'b1;
    tick();
    bus.add = 1'b0;
    tick();
    chk8("mid_partial", bus.data_out, 8'h06);
    rst_n = 1'b0;
    #1;
    chk8("mid_rst_data", bus.data_out, 8'h00);
    chk1("mid_rst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk1("post_rst_busy", bus.busy, 1'b0);
    chk1("post_rst_done", bus.done, 1'b0);
    for (int c = 0; c < 4; c++) begin
      bus.select = 2'(c);
      tick();
      chk8($sformatf("post_rst_ch%0d", c), bus.data_out, 8'h00);
      chk1($sformatf("post_rst_wrap%0d", c), bus.wrap_out, 1'b0);
    end

    // Operand digit F saturates to 9
    do_op("sat_done", 1'b0, 2'd1, 8'h0F);
    chk8("sat_value", bus.data_out, 8'h09);
    chk1("sat_wrap", bus.wrap_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
